// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - keypad operand entry sequencer for the FP16 adder
// Optional idle-timeout abandon of a partial entry: define KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry_ctrl #(
  parameter int          DIGITS         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        btn_clear,
  input  logic [15:0] add_result,
  input  logic        add_done,
  output logic        add_start,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [15:0] disp_val,
  output logic [2:0]  digit_cnt,
  output logic [1:0]  phase
);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);
  localparam logic [2:0] FULL_CNT   = 3'(DIGITS);

  state_t      state_q, state_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] result_q, result_d;
  logic [15:0] disp_val_q, disp_val_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic        add_start_q, add_start_d;
  logic        clear_pend_q, clear_pend_d;
  logic        do_clear;
  logic        timeout_hit;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        idle_counting;

  // Idle counter runs only while a user could still be typing or reading a result
  always_comb begin
    idle_counting = ((state_q == S_ENTER_A) && (digit_cnt_q != 3'd0)) ||
                    (state_q == S_ENTER_B) || (state_q == S_SHOW);
    timeout_hit   = idle_counting && (idle_q == 32'(TIMEOUT_CYCLES - 1));
    idle_d        = idle_q;
    if (key_valid || btn_clear || timeout_hit || (state_d != state_q)) begin
      idle_d = 32'd0;
    end else if (idle_counting) begin
      idle_d = idle_q + 32'd1;
    end
  end

  // Idle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= 32'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  wire unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Next-state, operand shifting and registered-output precomputation
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    digit_cnt_d  = digit_cnt_q;
    clear_pend_d = clear_pend_q;
    do_clear     = 1'b0;

    case (state_q)
      S_ENTER_A: begin
        if (btn_clear) begin
          do_clear = 1'b1;
        end else if (key_valid) begin
          op_a_d = {op_a_q[11:0], key_code};
          if (digit_cnt_q == LAST_DIGIT) begin
            state_d     = S_ENTER_B;
            digit_cnt_d = 3'd0;
            op_b_d      = 16'h0000;
          end else begin
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end
      end
      S_ENTER_B: begin
        if (btn_clear) begin
          do_clear = 1'b1;
        end else if (key_valid) begin
          op_b_d = {op_b_q[11:0], key_code};
          if (digit_cnt_q == LAST_DIGIT) begin
            state_d     = S_START;
            digit_cnt_d = FULL_CNT;
          end else begin
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end
      end
      S_START: begin
        // The adder has already been kicked; a clear must wait for its done
        if (btn_clear) begin
          clear_pend_d = 1'b1;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (btn_clear) begin
          clear_pend_d = 1'b1;
        end
        if (add_done) begin
          if (clear_pend_q || btn_clear) begin
            do_clear = 1'b1;
          end else begin
            result_d = add_result;
            state_d  = S_SHOW;
          end
        end
      end
      S_SHOW: begin
        if (btn_clear) begin
          do_clear = 1'b1;
        end else if (key_valid) begin
          op_a_d      = {12'h000, key_code};
          op_b_d      = 16'h0000;
          digit_cnt_d = 3'd1;
          state_d     = S_ENTER_A;
        end
      end
      default: begin
        do_clear = 1'b1;
      end
    endcase

    if (timeout_hit) begin
      do_clear = 1'b1;
    end

    if (do_clear) begin
      op_a_d       = 16'h0000;
      op_b_d       = 16'h0000;
      digit_cnt_d  = 3'd0;
      clear_pend_d = 1'b0;
      state_d      = S_ENTER_A;
    end

    add_start_d = (state_d == S_START);
    case (state_d)
      S_ENTER_A: begin
        phase_d    = 2'd0;
        disp_val_d = op_a_d;
      end
      S_ENTER_B: begin
        phase_d    = 2'd1;
        disp_val_d = op_b_d;
      end
      S_START, S_WAIT: begin
        phase_d    = 2'd2;
        disp_val_d = op_b_d;
      end
      default: begin
        phase_d    = 2'd3;
        disp_val_d = result_d;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ENTER_A;
      op_a_q       <= 16'h0000;
      op_b_q       <= 16'h0000;
      result_q     <= 16'h0000;
      disp_val_q   <= 16'h0000;
      digit_cnt_q  <= 3'd0;
      phase_q      <= 2'd0;
      add_start_q  <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      disp_val_q   <= disp_val_d;
      digit_cnt_q  <= digit_cnt_d;
      phase_q      <= phase_d;
      add_start_q  <= add_start_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  assign add_start = add_start_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign disp_val  = disp_val_q;
  assign digit_cnt = digit_cnt_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - directed scoreboard bench for keypad_entry_ctrl
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        btn_clear;
  logic [15:0] add_result;
  logic        add_done;
  logic        add_start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] disp_val;
  logic [2:0]  digit_cnt;
  logic [1:0]  phase;

  int tests = 0;
  int fails = 0;

  logic [31:0] op_sb[$];
  logic [15:0] res_sb[$];

  keypad_entry_ctrl #(.DIGITS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .btn_clear  (btn_clear),
    .add_result (add_result),
    .add_done   (add_done),
    .add_start  (add_start),
    .op_a       (op_a),
    .op_b       (op_b),
    .disp_val   (disp_val),
    .digit_cnt  (digit_cnt),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    btn_clear = 1'b1;
    tick();
    btn_clear = 1'b0;
  endtask

  task automatic done_pulse(input logic [15:0] r);
    add_result = r;
    add_done   = 1'b1;
    tick();
    add_done   = 1'b0;
  endtask

  // add_start must be high right after the edge that took the last B digit
  task automatic expect_add_start();
    logic [31:0] e;
    check("add_start_now", {15'd0, add_start}, 16'd1);
    if (op_sb.size() == 0) begin
      check("op_sb_nonempty", 16'd0, 16'd1);
    end else begin
      e = op_sb.pop_front();
      check("sb_op_a", op_a, e[31:16]);
      check("sb_op_b", op_b, e[15:0]);
    end
  endtask

  task automatic expect_show(input int budget);
    int n = 0;
    while (phase !== 2'd3 && n < budget) begin
      tick();
      n++;
    end
    check("show_phase", {14'd0, phase}, 16'd3);
    if (res_sb.size() == 0) begin
      check("res_sb_nonempty", 16'd0, 16'd1);
    end else begin
      check("sb_disp", disp_val, res_sb.pop_front());
    end
  endtask

  initial begin
    rst        = 1'b1;
    key_valid  = 1'b0;
    key_code   = 4'h0;
    btn_clear  = 1'b0;
    add_result = 16'h0000;
    add_done   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_op_a", op_a, 16'h0000);
    check("rst_op_b", op_b, 16'h0000);
    check("rst_disp", disp_val, 16'h0000);
    check("rst_cnt", {13'd0, digit_cnt}, 16'd0);
    check("rst_phase", {14'd0, phase}, 16'd0);
    check("rst_start", {15'd0, add_start}, 16'd0);

    // Full add 3C00 + 4000
    press(4'h3); press(4'hC); press(4'h0);
    check("a3_cnt", {13'd0, digit_cnt}, 16'd3);
    check("a3_disp", disp_val, 16'h03C0);
    press(4'h0);
    check("a_op_a", op_a, 16'h3C00);
    check("a_phase", {14'd0, phase}, 16'd1);
    check("a_cnt", {13'd0, digit_cnt}, 16'd0);
    press(4'h4); press(4'h0); press(4'h0);
    op_sb.push_back({16'h3C00, 16'h4000});
    press(4'h0);
    expect_add_start();
    check("start_phase", {14'd0, phase}, 16'd2);
    check("start_cnt", {13'd0, digit_cnt}, 16'd4);
    check("start_disp", disp_val, 16'h4000);
    tick();
    check("start_one_cycle", {15'd0, add_start}, 16'd0);
    res_sb.push_back(16'h4200);
    done_pulse(16'h4200);
    expect_show(4);

    // New entry from SHOW
    press(4'h5);
    check("show_key_phase", {14'd0, phase}, 16'd0);
    check("show_key_op_a", op_a, 16'h0005);
    check("show_key_cnt", {13'd0, digit_cnt}, 16'd1);
    clear_pulse();

    // Partial entry then clear
    press(4'h1); press(4'h2);
    check("part_op_a", op_a, 16'h0012);
    clear_pulse();
    check("clr_op_a", op_a, 16'h0000);
    check("clr_cnt", {13'd0, digit_cnt}, 16'd0);
    check("clr_phase", {14'd0, phase}, 16'd0);
    press(4'h7);
    check("after_clr_op_a", op_a, 16'h0007);

    // Stray add_done in ENTER_A
    done_pulse(16'hBEEF);
    check("stray_done_phase", {14'd0, phase}, 16'd0);
    check("stray_done_op_a", op_a, 16'h0007);
    check("stray_done_disp", disp_val, 16'h0007);

    // Key and clear together in ENTER_B
    press(4'h0); press(4'h0); press(4'h0);
    press(4'hA); press(4'hB);
    check("b_partial", op_b, 16'h00AB);
    key_valid = 1'b1;
    key_code  = 4'hC;
    btn_clear = 1'b1;
    tick();
    key_valid = 1'b0;
    btn_clear = 1'b0;
    check("kc_op_a", op_a, 16'h0000);
    check("kc_op_b", op_b, 16'h0000);
    check("kc_phase", {14'd0, phase}, 16'd0);
    check("kc_cnt", {13'd0, digit_cnt}, 16'd0);

    // Clear during WAIT discards the result
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    press(4'h5); press(4'h6); press(4'h7);
    op_sb.push_back({16'h1234, 16'h5678});
    press(4'h8);
    expect_add_start();
    tick();
    press(4'h9);
    check("wait_key_op_a", op_a, 16'h1234);
    check("wait_key_op_b", op_b, 16'h5678);
    check("wait_key_phase", {14'd0, phase}, 16'd2);
    clear_pulse();
    check("wait_clr_phase", {14'd0, phase}, 16'd2);
    done_pulse(16'h4200);
    check("pend_phase", {14'd0, phase}, 16'd0);
    check("pend_op_a", op_a, 16'h0000);
    check("pend_op_b", op_b, 16'h0000);
    check("pend_disp", disp_val, 16'h0000);

    // add_done during START is ignored; reset during WAIT
    press(4'h1); press(4'h1); press(4'h1); press(4'h1);
    press(4'h2); press(4'h2); press(4'h2);
    op_sb.push_back({16'h1111, 16'h2222});
    press(4'h2);
    expect_add_start();
    done_pulse(16'h5555);
    check("start_done_phase", {14'd0, phase}, 16'd2);
    check("start_done_disp", disp_val, 16'h2222);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrst_op_a", op_a, 16'h0000);
    check("wrst_op_b", op_b, 16'h0000);
    check("wrst_disp", disp_val, 16'h0000);
    check("wrst_phase", {14'd0, phase}, 16'd0);
    check("wrst_cnt", {13'd0, digit_cnt}, 16'd0);
    done_pulse(16'h4200);
    check("wrst_done_phase", {14'd0, phase}, 16'd0);
    check("wrst_done_disp", disp_val, 16'h0000);

    // Idle behaviour on a partial entry
    press(4'h9);
    for (int i = 0; i < 16; i++) tick();
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    check("idle_op_a", op_a, 16'h0000);
    check("idle_cnt", {13'd0, digit_cnt}, 16'd0);
`else
    check("idle_op_a", op_a, 16'h0009);
    check("idle_cnt", {13'd0, digit_cnt}, 16'd1);
`endif
    check("idle_phase", {14'd0, phase}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Sequences operand entry from the 4x4 hex keypad scanner into the half-precision adder.
- Consumes one-cycle decoded key events from the scanner/decoder and assembles two 16-bit operands, 4 hex digits each, MS digit first.
- Issues a start pulse to the FP16 adder, waits for its done handshake, then holds the sum for the display driver.
- Sits between the keypad scan/decode path and the adder/7-seg display logic.

Parameters:
- DIGITS, 4, hex digits per operand; fixed at 4 for FP16; other values unsupported.
- TIMEOUT_CYCLES, 500000000, idle cycles before entry abandon (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- key_valid  in  1  one-cycle pulse: new key pressed.
- key_code  in  4  hex value of the key, valid with key_valid.
- btn_clear  in  1  one-cycle pulse: abort/clear entry.
- add_result  in  16  FP16 sum from the adder, valid with add_done.
- add_done  in  1  one-cycle pulse from the adder.
- add_start  out  1  one-cycle pulse: op_a/op_b are valid, start the add.
- op_a  out  16  operand A register.
- op_b  out  16  operand B register.
- disp_val  out  16  value for the display.
- digit_cnt  out  3  digits entered in the current operand, 0..4.
- phase  out  2  0=ENTER_A, 1=ENTER_B, 2=BUSY (START/WAIT), 3=SHOW.

Behaviour:
- Reset: one clock, one synchronous active-high reset; clock is clk, reset is rst. On rst=1 at a posedge:
  - state=ENTER_A.
  - op_a=op_b=0, result=0, digit_cnt=0, add_start=0, disp_val=0, clear_pend=0.
  - rst overrides all other inputs in that cycle, including mid-add. An add_done arriving later is ignored.
- All outputs are registered.
- Digit shift: operand <= {operand[11:0], key_code}; digit_cnt += 1. The update is visible the cycle after the key_valid edge.
- ENTER_A:
  - key_valid: shift into op_a.
  - When this key is the 4th digit (digit_cnt was 3): at the same edge, state=ENTER_B, digit_cnt=0, op_b=0.
- ENTER_B:
  - key_valid: shift into op_b.
  - When this key is the 4th digit: state=START, digit_cnt=4.
- START: add_start=1 for exactly one cycle; next state=WAIT. key_valid is ignored.
- WAIT:
  - key_valid is ignored.
  - add_done: result<=add_result; state=SHOW.
  - add_done is sampled only in WAIT. Pulses in any other state, including the START cycle, are ignored.
- SHOW:
  - disp_val=result.
  - key_valid: op_a<={12'h000,key_code}, op_b=0, digit_cnt=1, state=ENTER_A. The key starts a new entry.
- disp_val:
  - ENTER_A shows op_a.
  - ENTER_B, START and WAIT show op_b.
  - SHOW shows result.
- btn_clear:
  - In ENTER_A, ENTER_B or SHOW: op_a=op_b=0, digit_cnt=0, state=ENTER_A.
  - In START or WAIT: sets clear_pend. The add completes; on add_done the result is discarded and the clear is applied, giving state=ENTER_A.
  - btn_clear together with key_valid: clear wins, key dropped.
- No add timeout: WAIT holds until add_done or rst.

Optional Feature:
- Macro: KEYPAD_ENTRY_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter increments in ENTER_A (with digit_cnt>0), ENTER_B and SHOW.
  - It resets on key_valid, btn_clear, any state change and rst.
  - On reaching TIMEOUT_CYCLES-1: apply the same effect as btn_clear (state=ENTER_A, operands 0).
  - The counter is frozen in START and WAIT.
- Undefined: no counter is present; partial entry is held indefinitely.

Test Plan:
- rst, then keys 3,C,0,0 -> op_a=16'h3C00, phase=1, digit_cnt=0; then keys 4,0,0,0 -> op_b=16'h4000, add_start high exactly 1 cycle after the 4th key edge; add_done with add_result=16'h4200 -> phase=3, disp_val=16'h4200.
- Keys 1,2 then btn_clear -> op_a=0, digit_cnt=0, phase=0; subsequent key 7 -> op_a=16'h0007.
- btn_clear during WAIT, then add_done with 16'h4200 -> disp_val≠16'h4200, phase=0, op_a=op_b=0.
- key_valid and btn_clear same cycle in ENTER_B with op_b=16'h00AB -> op_a=op_b=0, key dropped; key_valid during WAIT -> no operand change; add_done pulse in ENTER_A -> no effect.
- In SHOW, key 5 -> phase=0, op_a=16'h0005, digit_cnt=1; rst asserted during WAIT -> all outputs 0, later add_done ignored.
- With KEYPAD_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: key 9 then 16 idle cycles -> op_a=0, phase=0. Without the macro: op_a stays 16'h0009.
